seven_segment_capture: RTL

- Receiving end of the multiplexed 4-digit seven-segment display interface: monitors active-low segment lines (CA..CG, DP) and anode lines (AN1..AN4) and reconstructs the four displayed digits as 4-bit values.
- Used for board-level self-test and loopback checking of the display subsystem, and as a scoreboard front-end in system simulation.
- Decodes each strobed digit after a settle window, assembles a full frame, and publishes all four digits atomically.

---
 rtl/seven_segment_capture.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_capture.sv
// Seven-segment display receiver: rebuilds the four strobed digits and publishes them as one frame.
// Optional decimal-point capture is enabled by defining SSD_CAPTURE_DP_EN.
module seven_segment_capture #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CA,
    input  logic       CB,
    input  logic       CC,
    input  logic       CD,
    input  logic       CE,
    input  logic       CF,
    input  logic       CG,
    input  logic       DP,
    input  logic       AN1,
    input  logic       AN2,
    input  logic       AN3,
    input  logic       AN4,
    output logic [3:0] sec_dig1,
    output logic [3:0] sec_dig2,
    output logic [3:0] min_dig1,
    output logic [3:0] min_dig2,
    output logic [3:0] dp_captured,
    output logic       frame_valid,
    output logic       pattern_error,
    output logic       anode_error
);

`ifdef SSD_CAPTURE_DP_EN
    localparam int unsigned IN_W = 12;
`else
    localparam int unsigned IN_W = 11;
`endif
    localparam logic [7:0] SAMPLE_AT = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLING = 2'd1,
        HOLD     = 2'd2
    } state_t;

    logic [IN_W-1:0] raw_s;
    logic [IN_W-1:0] in_s;

`ifdef SSD_CAPTURE_DP_EN
    assign raw_s = {DP, AN4, AN3, AN2, AN1, CG, CF, CE, CD, CC, CB, CA};
`else
    assign raw_s = {AN4, AN3, AN2, AN1, CG, CF, CE, CD, CC, CB, CA};
`endif

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign in_s = raw_s;
        end else begin : g_sync
            logic [IN_W-1:0] sync_q [SYNC_STAGES];

            // Synchroniser chain; resets to the inactive (high) level of every line.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= {IN_W{1'b1}};
                    end
                end else begin
                    sync_q[0] <= raw_s;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign in_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Returns {valid, value}; segment order is {g,f,e,d,c,b,a}, active-high.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   seg_decode = 5'h10;
            7'h06:   seg_decode = 5'h11;
            7'h5B:   seg_decode = 5'h12;
            7'h4F:   seg_decode = 5'h13;
            7'h66:   seg_decode = 5'h14;
            7'h6D:   seg_decode = 5'h15;
            7'h7D:   seg_decode = 5'h16;
            7'h07:   seg_decode = 5'h17;
            7'h7F:   seg_decode = 5'h18;
            7'h6F:   seg_decode = 5'h19;
            7'h77:   seg_decode = 5'h1A;
            7'h7C:   seg_decode = 5'h1B;
            7'h39:   seg_decode = 5'h1C;
            7'h5E:   seg_decode = 5'h1D;
            7'h79:   seg_decode = 5'h1E;
            7'h71:   seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    logic [6:0] seg_s;
    logic [3:0] an_s;
    logic [4:0] dec_s;
    logic       an_none_s;
    logic       an_one_s;
    logic [1:0] an_idx_s;
    logic       eval_s;
    logic       sample_s;
    logic       capture_s;
    logic [3:0] mask_d;

    state_t     state_q;
    logic [3:0] an_lat_q;
    logic [1:0] sel_q;
    logic [7:0] cnt_q;
    logic [3:0] mask_q;
    logic [3:0] stage_q [4];
    logic [3:0] out_q   [4];
    logic       frame_valid_q;
    logic       pattern_error_q;
    logic       anode_error_q;

    assign seg_s     = ~in_s[6:0];
    assign an_s      = ~in_s[10:7];
    assign dec_s     = seg_decode(seg_s);
    assign an_none_s = (an_s == 4'b0000);
    assign an_one_s  = !an_none_s && ((an_s & (an_s - 4'd1)) == 4'b0000);

    // Index of the single active anode.
    always_comb begin
        case (an_s)
            4'b0001: an_idx_s = 2'd0;
            4'b0010: an_idx_s = 2'd1;
            4'b0100: an_idx_s = 2'd2;
            4'b1000: an_idx_s = 2'd3;
            default: an_idx_s = 2'd0;
        endcase
    end

    // Selection re-evaluation, sample strobe and next capture mask.
    always_comb begin
        eval_s    = (state_q == WAIT_SEL) || (an_s != an_lat_q);
        sample_s  = !eval_s && (state_q == SETTLING) && (cnt_q >= SAMPLE_AT);
        capture_s = sample_s && dec_s[4];
        if (mask_q == 4'hF) begin
            mask_d = 4'h0;
        end else begin
            mask_d = mask_q;
        end
        if (capture_s) begin
            mask_d[sel_q] = 1'b1;
        end else begin
            mask_d = mask_d;
        end
    end

    // Capture FSM with staging registers and frame publication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= WAIT_SEL;
            an_lat_q        <= 4'b0000;
            sel_q           <= 2'd0;
            cnt_q           <= 8'd0;
            mask_q          <= 4'b0000;
            frame_valid_q   <= 1'b0;
            pattern_error_q <= 1'b0;
            anode_error_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= 4'd0;
                out_q[i]   <= 4'd0;
            end
        end else begin
            mask_q          <= mask_d;
            frame_valid_q   <= (mask_q == 4'hF);
            pattern_error_q <= sample_s && !dec_s[4];
            anode_error_q   <= eval_s && !an_none_s && !an_one_s;
            if (mask_q == 4'hF) begin
                for (int i = 0; i < 4; i++) begin
                    out_q[i] <= stage_q[i];
                end
            end
            if (capture_s) begin
                stage_q[sel_q] <= dec_s[3:0];
            end
            if (eval_s) begin
                if (an_one_s) begin
                    an_lat_q <= an_s;
                    sel_q    <= an_idx_s;
                    cnt_q    <= 8'd1;
                    state_q  <= SETTLING;
                end else begin
                    cnt_q    <= 8'd0;
                    state_q  <= WAIT_SEL;
                end
            end else begin
                case (state_q)
                    SETTLING: begin
                        cnt_q <= cnt_q + 8'd1;
                        if (sample_s) begin
                            state_q <= HOLD;
                        end
                    end
                    HOLD:    state_q <= HOLD;
                    default: state_q <= WAIT_SEL;
                endcase
            end
        end
    end

`ifdef SSD_CAPTURE_DP_EN
    logic       dp_s;
    logic [3:0] dp_stage_q;
    logic [3:0] dp_out_q;

    assign dp_s = ~in_s[11];

    // Decimal points follow the same staging and publication path as the digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_stage_q <= 4'b0000;
            dp_out_q   <= 4'b0000;
        end else begin
            if (capture_s) begin
                dp_stage_q[sel_q] <= dp_s;
            end
            if (mask_q == 4'hF) begin
                dp_out_q <= dp_stage_q;
            end
        end
    end

    assign dp_captured = dp_out_q;
`else
    assign dp_captured = 4'b0000;
`endif

    assign sec_dig1      = out_q[0];
    assign sec_dig2      = out_q[1];
    assign min_dig1      = out_q[2];
    assign min_dig2      = out_q[3];
    assign frame_valid   = frame_valid_q;
    assign pattern_error = pattern_error_q;
    assign anode_error   = anode_error_q;

endmodule
